// File: rtl/mfp_ahb_sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module : mfp_ahb_const (package)
// Brief  : Shared constants for the AHB seven-segment display slave.
// Rev    : 1.0 - initial release
// ============================================================================
package mfp_ahb_const;

    localparam int          c_num_digits  = 8;

    localparam logic [1:0]  c_off_en      = 2'd0;
    localparam logic [1:0]  c_off_dhi     = 2'd1;
    localparam logic [1:0]  c_off_dlo     = 2'd2;
    localparam logic [1:0]  c_off_dp      = 2'd3;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mfp_ahb_sevenseg_if.sv
`default_nettype none
// ============================================================================
// Module : mfp_ahb_sevenseg_if
// Brief  : AHB-Lite slave-side signal bundle for the seven-segment block.
// Rev    : 1.0 - initial release
// ============================================================================
interface mfp_ahb_sevenseg_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface
`default_nettype wire

// File: rtl/mfp_ahb_sevenseg_decoder.sv
`default_nettype none
// ============================================================================
// Module : mfp_sevenseg_decoder
// Brief  : Hex nibble to active-high seven-segment pattern, bit0 = a .. bit6 = g.
// Rev    : 1.0 - initial release
// ============================================================================
module mfp_sevenseg_decoder (
    input  wire logic [3:0] i_hex,
    output logic      [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_sevenseg.sv
`default_nettype none
// ============================================================================
// Module : mfp_ahb_sevenseg
// Brief  : AHB-Lite slave driving an 8-digit multiplexed seven-segment display.
//          Define MFP_7SEG_READBACK_EN to enable register read-back on HRDATA.
// Rev    : 1.0 - initial release
// ============================================================================
module mfp_ahb_sevenseg #(
    parameter int DIGIT_SHIFT = 16
) (
    input  wire logic           HCLK,
    input  wire logic           HRESETn,
    mfp_ahb_sevenseg_if.slave   ahb,
    output logic      [7:0]     dispenout,
    output logic      [7:0]     disout
);

    import mfp_ahb_const::*;

    localparam int CNT_W = DIGIT_SHIFT + 3;

    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              w_idx;
    logic [c_num_digits-1:0] r_en;
    logic [c_num_digits-1:0] r_dp;
    logic [15:0]             r_dhi;
    logic [15:0]             r_dlo;
    logic                    r_wr_pend;
    logic [1:0]              r_addr_q;
    logic                    w_accept;
    logic [31:0]             w_nibbles;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic                    w_unused_bits;

    assign w_accept      = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign w_idx         = r_cnt[DIGIT_SHIFT+2:DIGIT_SHIFT];
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign w_unused_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0],
                             ahb.HWDATA[31:16]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Address phase: capture the transfer, write data arrives next cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_pend <= 1'b0;
            r_addr_q  <= 2'd0;
        end else begin
            r_wr_pend <= w_accept & ahb.HWRITE;
            if (w_accept) begin
                r_addr_q <= ahb.HADDR[3:2];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en  <= 8'hFF;
            r_dhi <= 16'h0000;
            r_dlo <= 16'h0000;
            r_dp  <= 8'h00;
        end else if (r_wr_pend) begin
            case (r_addr_q)
                c_off_en:  r_en  <= ahb.HWDATA[7:0];
                c_off_dhi: r_dhi <= ahb.HWDATA[15:0];
                c_off_dlo: r_dlo <= ahb.HWDATA[15:0];
                c_off_dp:  r_dp  <= ahb.HWDATA[7:0];
                default: ;
            endcase
        end
    end

`ifdef MFP_7SEG_READBACK_EN
    logic        r_rd_pend;
    logic [31:0] w_rdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_accept & ~ahb.HWRITE;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (r_rd_pend) begin
            case (r_addr_q)
                c_off_en:  w_rdata = {24'h0, r_en};
                c_off_dhi: w_rdata = {16'h0, r_dhi};
                c_off_dlo: w_rdata = {16'h0, r_dlo};
                c_off_dp:  w_rdata = {24'h0, r_dp};
                default:   w_rdata = 32'h0;
            endcase
        end
    end

    assign ahb.HRDATA = w_rdata;
`else
    assign ahb.HRDATA = 32'h0;
`endif

    // Digit 0 sits in the low nibble, digit 7 in the high nibble.
    assign w_nibbles = {r_dhi, r_dlo};
    assign w_nib     = w_nibbles[{w_idx, 2'b00} +: 4];

    mfp_sevenseg_decoder u_decoder (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    // A disabled digit still owns its slot so duty cycle never depends on EN.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dispenout <= 8'hFF;
            disout    <= 8'hFF;
        end else if (r_en[w_idx]) begin
            dispenout <= ~(8'b1 << w_idx);
            disout    <= ~{r_dp[w_idx], w_seg};
        end else begin
            dispenout <= 8'hFF;
            disout    <= 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: doc/mfp_ahb_sevenseg.md
Name: mfp_ahb_sevenseg

Overview:
- AHB-Lite slave that drives the board's 8-digit multiplexed seven-segment display.
- Sits on the bus fabric inside the AHB memory/IO subsystem, downstream of the MIPS core's AHB master port.
- Its outputs are the `dispenout` (active-low digit enables) and `disout` (active-low {DP, g..a}) pins exported at system top.
- Holds four software-visible registers and autonomously refreshes one digit at a time.

Parameters:
- DIGIT_SHIFT, 16, refresh counter bit at which the digit index starts; the digit index is cnt[DIGIT_SHIFT+2:DIGIT_SHIFT].
- CNT_W, DIGIT_SHIFT+3, refresh counter width (derived; not overridden).

Ports:
- HCLK  in  1  bus clock; sole clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address; only [3:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means active (NONSEQ/SEQ).
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus ready; qualifies the address phase.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, valid in the data phase.
- HREADYOUT  out  1  constant 1 (zero wait states).
- HRESP  out  1  constant 0 (OKAY).
- dispenout  out  8  active-low digit enables; bit i = digit i.
- disout  out  8  active-low segments; bit7 = DP, bits 6:0 = g..a.

Behaviour:
- Register map (offset = HADDR[3:2]):
  - 0 EN[7:0]: 1 = digit lit. Reset 8'hFF.
  - 1 DHI[15:0]: nibbles for digits 7..4, digit 7 in [15:12]. Reset 0.
  - 2 DLO[15:0]: nibbles for digits 3..0, digit 0 in [3:0]. Reset 0.
  - 3 DP[7:0]: 1 = point lit. Reset 0.
  - Unused upper bits of each register read 0; writes to them are ignored.
- Address phase:
  - A transfer is accepted when HSEL & HREADY & HTRANS[1].
  - On acceptance, wr_pend <= HWRITE and addr_q <= HADDR[3:2].
  - If not accepted, wr_pend <= 0.
- Data phase:
  - If wr_pend, the selected register loads the masked HWDATA at the next HCLK edge.
  - HSIZE is ignored; every write is treated as a full word.
- Back-to-back transfers: pipelined, one per cycle, no stalls.
  - A read issued in the cycle after a write to the same register returns the new value.
- Refresh:
  - cnt is a free-running CNT_W-bit counter that wraps to 0.
  - idx = cnt[DIGIT_SHIFT+2:DIGIT_SHIFT].
  - The digit index advances every 2^DIGIT_SHIFT cycles and steps 7 -> 0 on wrap.
- Output stage: registered; one cycle of latency from idx or register change.
  - dispenout <= ~(EN[idx] << idx).
  - If EN[idx], disout <= ~{DP[idx], seg(nibble[idx])}; otherwise disout <= 8'hFF.
- seg() decodes hex 0..F to standard a..g patterns; A..F render as A b C d E F.
- Reset values: cnt = 0, dispenout = 8'hFF, disout = 8'hFF, wr_pend = 0, addr_q = 0, registers as listed above.
- Reset asserted mid-transfer: the pending write is dropped and outputs blank immediately (asynchronous).
- A disabled digit keeps its time slot, so brightness is constant regardless of EN.

Optional Feature:
- Macro: MFP_7SEG_READBACK_EN.
- Defined: in a read data phase, HRDATA = zero-extended register[addr_q]; at all other times HRDATA = 0.
- Undefined: HRDATA is always 0, and the read mux and the addr_q read path are removed.
- Writes and refresh are identical in both builds.

Decomposition:
- Shared package mfp_ahb_const: register offset constants, the HTRANS_IDLE/NONSEQ encodings, and the digit count (8).
- One natural sub-module, mfp_sevenseg_decoder: combinational 4-bit to 7-bit active-high a..g decode. The top level inverts its output.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles, then release. Expect dispenout=8'hFF and disout=8'hFF during reset. After release, expect digit 0 lit showing "0": dispenout=8'hFE, disout=8'hC0.
- Write DLO=0x0003, DP=0x01, with DIGIT_SHIFT=2 for simulation. In digit-0 slot expect disout=8'h30, i.e. "3" with DP lit.
- Write EN=0x00. Within one refresh slot expect dispenout=8'hFF and disout=8'hFF in every slot.
- Back-to-back: write DHI=0xABCD, then read DHI in the next cycle (READBACK_EN defined). Expect HRDATA=0x0000ABCD. Expect digit 7 to show "A" (disout=8'h88) in its slot.
- Idle and unselected traffic: HTRANS=IDLE or HSEL=0 with HWRITE=1 and HWDATA=0xFFFF. Expect registers unchanged; HREADYOUT stays 1 and HRESP stays 0.
- Wrap: run 8·2^DIGIT_SHIFT cycles. Expect dispenout to step FE, FD, FB, ..., 7F, then FE again.
